wb_interconnect_nx: RTL and testbench

Parametrised single-master, N-slave Wishbone interconnect with registered request path, address decode, registered response and bus-error generation. It sits between the user-project Wishbone port (master 0) and the peripheral set (SRAM, UART, TRNG, SPI, plus future slaves). It adds three behaviours: per-slave cyc/stb selection, an error response for unmapped addresses, and a watchdog timeout for slaves that never acknowledge.

---
 rtl/wb_interconnect_nx.sv | 179 +++++++++++++++++
 tb/tb_wb_interconnect_nx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect_nx.sv
// wb_interconnect_nx: single-master, N-slave Wishbone interconnect.
// The request path is registered and the slave is chosen by decoding an address field.
// The response is registered. Unmapped addresses and slaves that never ack both end in a bus error.
module wb_interconnect_nx #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SEL_MSB    = 13,
    parameter int unsigned SEL_LSB    = 12,
    parameter int unsigned SLV_ADR_W  = 10,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              m0_wb_dat_i,
    input  logic [31:0]              m0_wb_adr_i,
    input  logic [3:0]               m0_wb_sel_i,
    input  logic                     m0_wb_we_i,
    input  logic                     m0_wb_cyc_i,
    input  logic                     m0_wb_stb_i,
    output logic [31:0]              m0_wb_dat_o,
    output logic                     m0_wb_ack_o,
    output logic                     m0_wb_err_o,
    input  logic [32*NUM_SLAVES-1:0] s_wb_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_wb_ack_i,
    output logic [31:0]              s_wb_dat_o,
    output logic [SLV_ADR_W-1:0]     s_wb_adr_o,
    output logic [3:0]               s_wb_sel_o,
    output logic                     s_wb_we_o,
    output logic [NUM_SLAVES-1:0]    s_wb_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_wb_stb_o
);

    localparam int unsigned SEL_W = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            r_state,  w_state_nxt;
    logic [CNT_W-1:0]      r_cnt,    w_cnt_nxt;
    logic [SEL_W-1:0]      r_idx,    w_idx_nxt;
    logic [31:0]           r_m_dat,  w_m_dat_nxt;
    logic                  r_ack,    w_ack_nxt;
    logic                  r_err,    w_err_nxt;
    logic [31:0]           r_s_dat,  w_s_dat_nxt;
    logic [SLV_ADR_W-1:0]  r_s_adr,  w_s_adr_nxt;
    logic [3:0]            r_s_sel,  w_s_sel_nxt;
    logic                  r_s_we,   w_s_we_nxt;
    logic [NUM_SLAVES-1:0] r_oh,     w_oh_nxt;

    logic [SEL_W-1:0]      w_req_idx;
    logic                  w_mapped;
    logic [NUM_SLAVES-1:0] w_req_oh;
    logic                  w_sel_ack;
    logic [31:0]           w_sel_dat;
    logic                  w_unused;

    // Address bits outside the select and word fields are intentionally ignored
    assign w_unused  = ^m0_wb_adr_i;
    assign w_req_idx = m0_wb_adr_i[SEL_MSB:SEL_LSB];
    assign w_mapped  = (32'(w_req_idx) < NUM_SLAVES);

    // Build the one-hot slave select for an incoming request
    always_comb begin
        w_req_oh = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_req_oh[k] = (w_req_idx == SEL_W'(k));
        end
    end

    // Pick the ack and read data of the latched slave; all other acks are ignored
    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_idx == SEL_W'(k)) begin
                w_sel_ack = s_wb_ack_i[k];
                w_sel_dat = s_wb_dat_i[32*k +: 32];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_m_dat_nxt = r_m_dat;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_s_dat_nxt = r_s_dat;
        w_s_adr_nxt = r_s_adr;
        w_s_sel_nxt = r_s_sel;
        w_s_we_nxt  = r_s_we;
        w_oh_nxt    = '0;
        case (r_state)
            ST_IDLE: begin
                if (m0_wb_cyc_i && m0_wb_stb_i) begin
                    if (w_mapped) begin
                        w_idx_nxt   = w_req_idx;
                        w_s_dat_nxt = m0_wb_dat_i;
                        w_s_adr_nxt = m0_wb_adr_i[SLV_ADR_W+1:2];
                        w_s_sel_nxt = m0_wb_sel_i;
                        w_s_we_nxt  = m0_wb_we_i;
                        w_cnt_nxt   = '0;
                        w_oh_nxt    = w_req_oh;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_m_dat_nxt = '0;
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                if (!m0_wb_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sel_ack) begin
                    w_ack_nxt   = 1'b1;
                    w_m_dat_nxt = w_sel_dat;
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_m_dat_nxt = '0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_oh_nxt    = r_oh;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_m_dat <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_s_dat <= '0;
            r_s_adr <= '0;
            r_s_sel <= '0;
            r_s_we  <= 1'b0;
            r_oh    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_m_dat <= w_m_dat_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_s_dat <= w_s_dat_nxt;
            r_s_adr <= w_s_adr_nxt;
            r_s_sel <= w_s_sel_nxt;
            r_s_we  <= w_s_we_nxt;
            r_oh    <= w_oh_nxt;
        end
    end

    assign m0_wb_dat_o = r_m_dat;
    assign m0_wb_ack_o = r_ack;
    assign m0_wb_err_o = r_err;
    assign s_wb_dat_o  = r_s_dat;
    assign s_wb_adr_o  = r_s_adr;
    assign s_wb_sel_o  = r_s_sel;
    assign s_wb_we_o   = r_s_we;
    assign s_wb_cyc_o  = r_oh;
    assign s_wb_stb_o  = r_oh;

endmodule

// File: tb/tb_wb_interconnect_nx.sv
// Bench for wb_interconnect_nx: directed transfers and a transaction-level reference model.
// The model is checked against the DUT on every cycle.
module tb_wb_interconnect_nx;

    localparam int unsigned NS  = 3;
    localparam int unsigned TMO = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [31:0]       m0_wb_dat_i, m0_wb_adr_i;
    logic [3:0]        m0_wb_sel_i;
    logic              m0_wb_we_i, m0_wb_cyc_i, m0_wb_stb_i;
    logic [31:0]       m0_wb_dat_o;
    logic              m0_wb_ack_o, m0_wb_err_o;
    logic [32*NS-1:0]  s_wb_dat_i;
    logic [NS-1:0]     s_wb_ack_i;
    logic [31:0]       s_wb_dat_o;
    logic [9:0]        s_wb_adr_o;
    logic [3:0]        s_wb_sel_o;
    logic              s_wb_we_o;
    logic [NS-1:0]     s_wb_cyc_o, s_wb_stb_o;

    wb_interconnect_nx #(
        .NUM_SLAVES(NS), .SEL_MSB(13), .SEL_LSB(12), .SLV_ADR_W(10), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_sel_i(m0_wb_sel_i),
        .m0_wb_we_i(m0_wb_we_i), .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i),
        .m0_wb_dat_o(m0_wb_dat_o), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
        .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i),
        .s_wb_dat_o(s_wb_dat_o), .s_wb_adr_o(s_wb_adr_o), .s_wb_sel_o(s_wb_sel_o),
        .s_wb_we_o(s_wb_we_o), .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transfer in flight, aged in cycles since acceptance
    bit          m_valid = 1'b0;
    bit          m_inflight;
    int          m_slave;
    int          m_age;
    bit          m_ack, m_err;
    logic [31:0] m_rdat, m_sdat;
    logic [9:0]  m_sadr;
    logic [3:0]  m_ssel;
    bit          m_swe;
    int unsigned tb_idx;

    assign tb_idx = (m0_wb_adr_i / 4096) % 4;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_valid <= 1'b1; m_inflight <= 1'b0; m_slave <= 0; m_age <= 0;
            m_ack <= 1'b0; m_err <= 1'b0; m_rdat <= '0; m_sdat <= '0;
            m_sadr <= '0; m_ssel <= '0; m_swe <= 1'b0;
        end else begin
            m_ack <= 1'b0;
            m_err <= 1'b0;
            if (m_ack || m_err) begin
                // response cycle: no new request is taken
            end else if (m_inflight) begin
                if (!m0_wb_cyc_i) begin
                    m_inflight <= 1'b0;
                end else if (s_wb_ack_i[m_slave]) begin
                    m_inflight <= 1'b0;
                    m_ack      <= 1'b1;
                    m_rdat     <= s_wb_dat_i[32*m_slave +: 32];
                end else if (m_age == TMO) begin
                    m_inflight <= 1'b0;
                    m_err      <= 1'b1;
                    m_rdat     <= '0;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (m0_wb_cyc_i && m0_wb_stb_i) begin
                if (tb_idx < NS) begin
                    m_inflight <= 1'b1;
                    m_slave    <= int'(tb_idx);
                    m_age      <= 1;
                    m_sdat     <= m0_wb_dat_i;
                    m_sadr     <= 10'((m0_wb_adr_i / 4) % 1024);
                    m_ssel     <= m0_wb_sel_i;
                    m_swe      <= m0_wb_we_i;
                end else begin
                    m_err  <= 1'b1;
                    m_rdat <= '0;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk_i) begin
        if (m_valid) begin
            check("mdl_ack", 32'(m0_wb_ack_o), 32'(m_ack));
            check("mdl_err", 32'(m0_wb_err_o), 32'(m_err));
            check("mdl_mdat", m0_wb_dat_o, m_rdat);
            check("mdl_stb", 32'(s_wb_stb_o), m_inflight ? (32'd1 << m_slave) : 32'd0);
            check("mdl_cyc", 32'(s_wb_cyc_o), m_inflight ? (32'd1 << m_slave) : 32'd0);
            check("mdl_sdat", s_wb_dat_o, m_sdat);
            check("mdl_sadr", 32'(s_wb_adr_o), 32'(m_sadr));
            check("mdl_ssel", 32'(s_wb_sel_o), 32'(m_ssel));
            check("mdl_swe", 32'(s_wb_we_o), 32'(m_swe));
        end
    end

    task automatic req(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
        m0_wb_adr_i = adr; m0_wb_dat_i = dat; m0_wb_sel_i = sel; m0_wb_we_i = we;
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1;
    endtask

    task automatic idle_m();
        m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
    endtask

    task automatic sack(input int k, input logic [31:0] d);
        s_wb_ack_i[k] = 1'b1;
        s_wb_dat_i[32*k +: 32] = d;
    endtask

    int cnt_stb;
    int err_cyc;

    initial begin
        rst_i = 1'b1;
        m0_wb_dat_i = '0; m0_wb_adr_i = '0; m0_wb_sel_i = '0; m0_wb_we_i = 1'b0;
        idle_m();
        s_wb_dat_i = '0; s_wb_ack_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_ack", 32'(m0_wb_ack_o), 32'd0);
        check("rst_stb", 32'(s_wb_stb_o), 32'd0);
        check("rst_mdat", m0_wb_dat_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Read slave 2, zero wait
        req(32'h0000_2010, 32'h0, 4'hF, 1'b0);
        @(negedge clk_i);
        check("rd_adr", 32'(s_wb_adr_o), 32'h004);
        check("rd_stb", 32'(s_wb_stb_o), 32'b100);
        check("rd_noack_early", 32'(m0_wb_ack_o), 32'd0);
        sack(2, 32'hA5A5_1234);
        @(negedge clk_i);
        check("rd_ack", 32'(m0_wb_ack_o), 32'd1);
        check("rd_dat", m0_wb_dat_o, 32'hA5A5_1234);
        s_wb_ack_i = '0; idle_m();
        @(negedge clk_i);
        check("rd_ack_1cyc", 32'(m0_wb_ack_o), 32'd0);

        // Write slave 1, three wait cycles
        req(32'h0000_1008, 32'hCAFE_F00D, 4'b0011, 1'b1);
        @(negedge clk_i);
        check("wr_we", 32'(s_wb_we_o), 32'd1);
        check("wr_sel", 32'(s_wb_sel_o), 32'b0011);
        check("wr_adr", 32'(s_wb_adr_o), 32'h002);
        check("wr_sdat", s_wb_dat_o, 32'hCAFE_F00D);
        repeat (3) @(negedge clk_i);
        sack(1, 32'h1111_2222);
        @(negedge clk_i);
        check("wr_ack", 32'(m0_wb_ack_o), 32'd1);
        check("wr_noerr", 32'(m0_wb_err_o), 32'd0);
        s_wb_ack_i = '0; idle_m();
        @(negedge clk_i);

        // Unmapped access
        req(32'h0000_3000, 32'h0, 4'hF, 1'b0);
        @(negedge clk_i);
        check("um_stb", 32'(s_wb_stb_o), 32'd0);
        check("um_err", 32'(m0_wb_err_o), 32'd1);
        check("um_noack", 32'(m0_wb_ack_o), 32'd0);
        check("um_dat", m0_wb_dat_o, 32'd0);
        idle_m();
        @(negedge clk_i);
        check("um_err_1cyc", 32'(m0_wb_err_o), 32'd0);

        // Timeout on slave 0
        req(32'h0000_0040, 32'h0, 4'hF, 1'b0);
        cnt_stb = 0; err_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (m0_wb_err_o) begin
                err_cyc = i + 1;
                break;
            end
            if (s_wb_stb_o[0]) cnt_stb++;
        end
        check("to_stb_cycles", 32'(cnt_stb), 32'd8);
        check("to_err_cycle", 32'(err_cyc), 32'd9);
        idle_m();
        @(negedge clk_i);
        req(32'h0000_0004, 32'h0, 4'hF, 1'b0);
        @(negedge clk_i);
        check("to_next_stb", 32'(s_wb_stb_o), 32'b001);
        sack(0, 32'h0BAD_BEEF);
        @(negedge clk_i);
        check("to_next_ack", 32'(m0_wb_ack_o), 32'd1);
        check("to_next_dat", m0_wb_dat_o, 32'h0BAD_BEEF);
        s_wb_ack_i = '0; idle_m();
        @(negedge clk_i);

        // Ack in the last cycle before timeout wins
        req(32'h0000_0000, 32'h0, 4'hF, 1'b0);
        repeat (8) @(negedge clk_i);
        sack(0, 32'h0000_0077);
        @(negedge clk_i);
        check("late_ack", 32'(m0_wb_ack_o), 32'd1);
        check("late_noerr", 32'(m0_wb_err_o), 32'd0);
        check("late_dat", m0_wb_dat_o, 32'h0000_0077);
        s_wb_ack_i = '0; idle_m();
        @(negedge clk_i);

        // Acks from non-selected slaves are ignored
        req(32'h0000_1000, 32'h0, 4'hF, 1'b0);
        @(negedge clk_i);
        s_wb_dat_i = {32'hDDDD_0002, 32'h5555_AAAA, 32'hDDDD_0000};
        s_wb_ack_i = 3'b101;
        @(negedge clk_i);
        check("stray_stb", 32'(s_wb_stb_o), 32'b010);
        check("stray_noack", 32'(m0_wb_ack_o), 32'd0);
        s_wb_ack_i = 3'b010;
        @(negedge clk_i);
        check("stray_ack", 32'(m0_wb_ack_o), 32'd1);
        check("stray_dat", m0_wb_dat_o, 32'h5555_AAAA);
        s_wb_ack_i = '0; idle_m();
        @(negedge clk_i);

        // Abort in second BUSY cycle, with a simultaneous ack
        req(32'h0000_1004, 32'h0, 4'hF, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        idle_m();
        sack(1, 32'hEEEE_EEEE);
        @(negedge clk_i);
        check("ab_stb", 32'(s_wb_stb_o), 32'd0);
        check("ab_noack", 32'(m0_wb_ack_o), 32'd0);
        check("ab_noerr", 32'(m0_wb_err_o), 32'd0);
        s_wb_ack_i = '0;
        @(negedge clk_i);
        check("ab_noack2", 32'(m0_wb_ack_o), 32'd0);

        // Reset in second BUSY cycle
        req(32'h0000_2008, 32'h1234_5678, 4'b1010, 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rr_stb", 32'(s_wb_stb_o), 32'd0);
        check("rr_cyc", 32'(s_wb_cyc_o), 32'd0);
        check("rr_ack", 32'(m0_wb_ack_o), 32'd0);
        check("rr_err", 32'(m0_wb_err_o), 32'd0);
        check("rr_mdat", m0_wb_dat_o, 32'd0);
        check("rr_sdat", s_wb_dat_o, 32'd0);
        check("rr_sadr", 32'(s_wb_adr_o), 32'd0);
        check("rr_ssel", 32'(s_wb_sel_o), 32'd0);
        check("rr_swe", 32'(s_wb_we_o), 32'd0);
        rst_i = 1'b0;
        idle_m();
        repeat (3) @(negedge clk_i);
        check("rr_idle_ack", 32'(m0_wb_ack_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
